// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: memory-sequencer state
// encoding, the default timeout and the load-use source-match helper.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } mem_state_t;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W           = 16;

    function automatic logic src_hit(
        input logic       use_src,
        input logic [4:0] src,
        input logic [4:0] rd
    );
        return use_src && (src == rd);
    endfunction

endpackage

// File: rtl/mem_seq_fsm.sv
// Data-memory sequencer: IDLE/REQ/WAIT/DONE/ERR with a 16-bit wait counter
// and a sticky timeout flag. Request valid and timeout flag are state-only.
module mem_seq_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_mem_valid,
    input  logic       i_dmem_ready,
    input  logic       i_dmem_resp_valid,
    output mem_state_t o_state,
    output logic       o_req_valid,
    output logic       o_timeout_err
);

    mem_state_t       r_state;
    mem_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;
    logic [CNT_W:0]   w_cnt_inc;
    logic             w_timeout_hit;

    // The check looks one count ahead so ERR is entered after exactly
    // TIMEOUT cycles spent in REQ+WAIT.
    assign w_cnt_inc     = {1'b0, r_cnt} + 17'd1;
    assign w_timeout_hit = (w_cnt_inc >= 17'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_mem_valid) w_next_state = ST_REQ;
            end
            ST_REQ: begin
                // Completion in the acceptance cycle beats a coincident timeout.
                if (i_dmem_ready && i_dmem_resp_valid) w_next_state = ST_DONE;
                else if (w_timeout_hit)                w_next_state = ST_ERR;
                else if (i_dmem_ready)                 w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_dmem_resp_valid)  w_next_state = ST_DONE;
                else if (w_timeout_hit) w_next_state = ST_ERR;
            end
            ST_DONE: w_next_state = ST_IDLE;
            ST_ERR:  w_next_state = ST_ERR;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE && w_next_state == ST_REQ) begin
            r_cnt <= '0;
        end else if (r_state == ST_REQ || r_state == ST_WAIT) begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else if (w_next_state == ST_ERR) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign o_state       = r_state;
    assign o_req_valid   = (r_state == ST_REQ);
    assign o_timeout_err = r_timeout_err;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory stall > branch flush > load-use stall.
// All stall/flush/bubble outputs are combinational; memory state lives in mem_seq_fsm.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] decode_rs1,
    input  logic [4:0] decode_rs2,
    input  logic       decode_use_rs1,
    input  logic       decode_use_rs2,
    input  logic       regE_is_load,
    input  logic [4:0] regE_wb_rd,
    input  logic       execute_branch_jump,
    input  logic       regM_mem_valid,
    input  logic       dmem_ready,
    input  logic       dmem_resp_valid,
    output logic       dmem_req_valid,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       stall_M,
    output logic       flush_D,
    output logic       flush_E,
    output logic       bubble_W,
    output logic       timeout_err
);

    mem_state_t w_state;
    logic       w_mem_busy;
    logic       w_load_use;

    mem_seq_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_seq (
        .clk               (clk),
        .rst               (rst),
        .i_mem_valid       (regM_mem_valid),
        .i_dmem_ready      (dmem_ready),
        .i_dmem_resp_valid (dmem_resp_valid),
        .o_state           (w_state),
        .o_req_valid       (dmem_req_valid),
        .o_timeout_err     (timeout_err)
    );

    // IDLE with a pending M op already stalls, so the detect cycle counts as busy.
    assign w_mem_busy = ((w_state == ST_IDLE) && regM_mem_valid)
                      || (w_state == ST_REQ)
                      || (w_state == ST_WAIT)
                      || (w_state == ST_ERR);

    assign w_load_use = regE_is_load && (regE_wb_rd != 5'd0)
                      && (src_hit(decode_use_rs1, decode_rs1, regE_wb_rd)
                       || src_hit(decode_use_rs2, decode_rs2, regE_wb_rd));

    always_comb begin
        stall_F  = 1'b0;
        stall_D  = 1'b0;
        stall_E  = 1'b0;
        stall_M  = 1'b0;
        flush_D  = 1'b0;
        flush_E  = 1'b0;
        bubble_W = 1'b0;
        if (w_mem_busy) begin
            stall_F  = 1'b1;
            stall_D  = 1'b1;
            stall_E  = 1'b1;
            stall_M  = 1'b1;
            bubble_W = 1'b1;
        end else if (execute_branch_jump) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (w_load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed spec scenarios plus random traffic
// against a transaction-level memory model; a negedge monitor pops and compares.
module tb_pipe_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] decode_rs1, decode_rs2, regE_wb_rd;
    logic       decode_use_rs1, decode_use_rs2, regE_is_load;
    logic       execute_branch_jump, regM_mem_valid, dmem_ready, dmem_resp_valid;
    logic       dmem_req_valid, stall_F, stall_D, stall_E, stall_M;
    logic       flush_D, flush_E, bubble_W, timeout_err;

    pipe_ctrl #(.TIMEOUT(TO)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .decode_rs1          (decode_rs1),
        .decode_rs2          (decode_rs2),
        .decode_use_rs1      (decode_use_rs1),
        .decode_use_rs2      (decode_use_rs2),
        .regE_is_load        (regE_is_load),
        .regE_wb_rd          (regE_wb_rd),
        .execute_branch_jump (execute_branch_jump),
        .regM_mem_valid      (regM_mem_valid),
        .dmem_ready          (dmem_ready),
        .dmem_resp_valid     (dmem_resp_valid),
        .dmem_req_valid      (dmem_req_valid),
        .stall_F             (stall_F),
        .stall_D             (stall_D),
        .stall_E             (stall_E),
        .stall_M             (stall_M),
        .flush_D             (flush_D),
        .flush_E             (flush_E),
        .bubble_W            (bubble_W),
        .timeout_err         (timeout_err)
    );

    always #5 clk = ~clk;

    // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W, dmem_req_valid, timeout_err}
    logic [8:0] act;
    assign act = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W,
                  dmem_req_valid, timeout_err};

    typedef struct {
        logic [8:0] mdl;
        logic [8:0] spec;
        bit         has_spec;
        int         tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cyc    = 0;

    // Transaction-level view of the memory op in flight.
    bit m_active, m_accepted, m_done, m_err;
    int m_cycles;

    task automatic check(input string name, input logic [8:0] a, input logic [8:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_accepted = 0; m_done = 0; m_err = 0; m_cycles = 0;
    endtask

    function automatic logic [8:0] model_out();
        logic busy, lu, req;
        logic [8:0] v;
        busy = m_err || m_active || (!m_done && regM_mem_valid);
        req  = m_active && !m_accepted;
        lu   = regE_is_load && (regE_wb_rd != 0) &&
               ((decode_use_rs1 && decode_rs1 == regE_wb_rd) ||
                (decode_use_rs2 && decode_rs2 == regE_wb_rd));
        if (busy)                     v = 9'b111100100;
        else if (execute_branch_jump) v = 9'b000011000;
        else if (lu)                  v = 9'b110001000;
        else                          v = 9'b000000000;
        v[1] = req;
        v[0] = m_err;
        return v;
    endfunction

    task automatic model_tick();
        bit completes;
        if (rst) begin
            model_reset();
        end else if (m_err) begin
            m_err = 1;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            m_cycles++;
            completes = m_accepted ? dmem_resp_valid : (dmem_ready && dmem_resp_valid);
            if (completes) begin
                m_active = 0;
                m_done   = 1;
            end else if (m_cycles >= TO) begin
                m_active = 0;
                m_err    = 1;
            end else if (dmem_ready) begin
                m_accepted = 1;
            end
        end else if (regM_mem_valid) begin
            m_active   = 1;
            m_accepted = 0;
            m_cycles   = 0;
        end
    endtask

    task automatic apply(input logic r, mv, rdy, rsp, br, ld, input logic [4:0] rd, s1, s2,
                         input logic u1, u2, input bit hs, input logic [8:0] sp);
        exp_t e;
        rst = r; regM_mem_valid = mv; dmem_ready = rdy; dmem_resp_valid = rsp;
        execute_branch_jump = br; regE_is_load = ld; regE_wb_rd = rd;
        decode_rs1 = s1; decode_rs2 = s2; decode_use_rs1 = u1; decode_use_rs2 = u2;
        if (r) model_reset();
        e.mdl = model_out(); e.spec = sp; e.has_spec = hs; e.tag = n_cyc;
        sb.push_back(e);
        n_cyc++;
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic d(input logic r, mv, rdy, rsp, br, ld, input logic [4:0] rd, s1,
                     input logic u1, input logic [8:0] sp);
        apply(r, mv, rdy, rsp, br, ld, rd, s1, 5'd0, u1, 1'b0, 1'b1, sp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("model_cyc%0d", e.tag), act, e.mdl);
                if (e.has_spec) check($sformatf("spec_cyc%0d", e.tag), act, e.spec);
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        regM_mem_valid = 0; dmem_ready = 0; dmem_resp_valid = 0; execute_branch_jump = 0;
        regE_is_load = 0; regE_wb_rd = 0; decode_rs1 = 0; decode_rs2 = 0;
        decode_use_rs1 = 0; decode_use_rs2 = 0;
        model_reset();
        #1;
        check("reset_state", act, 9'b000000000);
        @(posedge clk);
        #1;

        // load-use, rd=0 exemption, branch beats load-use
        d(0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 9'b110001000);
        d(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 9'b000000000);
        d(0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 9'b000011000);

        // memory op with a branch held throughout: flush only in the DONE cycle
        d(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 9'b111100100);
        d(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 9'b111100110);
        d(0, 1, 1, 0, 1, 0, 5'd0, 5'd0, 0, 9'b111100110);
        d(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 9'b111100100);
        d(0, 1, 0, 1, 1, 0, 5'd0, 5'd0, 0, 9'b111100100);
        d(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 9'b000011000);
        d(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 9'b000000000);

        // timeout: four REQ cycles without ready, then absorbing ERR
        d(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 9'b111100100);
        for (int i = 0; i < TO; i++)
            d(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 9'b111100110);
        d(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 9'b111100101);
        d(0, 0, 1, 1, 1, 0, 5'd0, 5'd0, 0, 9'b111100101);
        d(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 9'b000000000);

        // reset in WAIT abandons the op; the next one starts fresh
        d(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 9'b111100100);
        d(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 9'b111100110);
        d(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 9'b111100100);
        d(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 9'b000000000);
        d(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 9'b111100100);
        d(0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 9'b111100110);
        d(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 9'b000000000);
        d(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 9'b000000000);

        for (int i = 0; i < 1500; i++) begin
            apply($urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  1'b0, 9'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
